// File: rtl/eth_sw_pkg.sv
// ---------------------------------------------------------------------------
// eth_sw_pkg
// Shared types and defaults for the 2-port Ethernet switch egress scheduler.
//   arb_state_e : egress arbiter FSM states
//   src_e       : identifies one of the two ingress sources (A or B)
//   DEFAULT_*   : default parameter values used by eth_sw_out_arb
//   WORD_CNT_W  : width of the in-packet word counter; wide enough for the
//                 largest supported MAX_PKT_WORDS (65535)
// ---------------------------------------------------------------------------
package eth_sw_pkg;

  localparam int DEFAULT_DW            = 32;
  localparam int DEFAULT_MAX_PKT_WORDS = 64;
  localparam int DEFAULT_CNT_W         = 16;
  localparam int WORD_CNT_W            = 16;

  typedef enum logic [2:0] {
    IDLE,
    XFER_A,
    XFER_B,
    DRAIN_A,
    DRAIN_B
  } arb_state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/eth_sw_rr_arb2.sv
// ---------------------------------------------------------------------------
// eth_sw_rr_arb2
// Two-way round-robin pick, purely combinational.
// Ports:
//   req[1:0]    in  : request vector, bit 0 = source A, bit 1 = source B
//   last_grant  in  : source that won the previous arbitration
//   gnt[1:0]    out : one-hot grant, or 0 when nothing is requested
// ---------------------------------------------------------------------------
module eth_sw_rr_arb2
  import eth_sw_pkg::*;
(
  input  logic [1:0] req,
  input  src_e       last_grant,
  output logic [1:0] gnt
);

  // On a tie the source that did not win last time gets the port.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == SRC_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/eth_sw_out_arb.sv
// ---------------------------------------------------------------------------
// eth_sw_out_arb
// Egress-port scheduler for the 2-port Ethernet switch (one per egress port).
// Shares the egress port between ingress sources A and B with packet-granular
// round-robin, honours the egress stall and truncates over-long packets.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   srcA_valid/data/sop/eop      : source A word stream (in)
//   srcA_ready                   : source A word accepted when valid&ready
//   srcB_*                       : same set for source B
//   port_stall                   : egress cannot accept this cycle
//   out_valid/data/sop/eop       : registered egress stream (latency 1)
//   grant_a, grant_b             : which source currently owns the egress
//   pkt_cnt_a, pkt_cnt_b         : packets forwarded per source (wrapping)
//   err_len                      : 1-cycle pulse with a truncated last word
// ---------------------------------------------------------------------------
module eth_sw_out_arb
  import eth_sw_pkg::*;
#(
  parameter int DW            = DEFAULT_DW,
  parameter int MAX_PKT_WORDS = DEFAULT_MAX_PKT_WORDS,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srcA_valid,
  input  logic [DW-1:0]    srcA_data,
  input  logic             srcA_sop,
  input  logic             srcA_eop,
  output logic             srcA_ready,
  input  logic             srcB_valid,
  input  logic [DW-1:0]    srcB_data,
  input  logic             srcB_sop,
  input  logic             srcB_eop,
  output logic             srcB_ready,
  input  logic             port_stall,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             grant_a,
  output logic             grant_b,
  output logic [CNT_W-1:0] pkt_cnt_a,
  output logic [CNT_W-1:0] pkt_cnt_b,
  output logic             err_len
);

  // Index of the last word a packet may occupy before it gets truncated.
  localparam logic [WORD_CNT_W-1:0] LAST_IDX = WORD_CNT_W'(MAX_PKT_WORDS - 1);

  arb_state_e              state_q, state_d;
  src_e                    last_grant_q, last_grant_d;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DW-1:0]           out_data_q, out_data_d;
  logic                    out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d;
  logic                    err_len_q, err_len_d;
  logic [CNT_W-1:0]        pkt_cnt_a_q, pkt_cnt_a_d;
  logic [CNT_W-1:0]        pkt_cnt_b_q, pkt_cnt_b_d;

  logic [1:0]              req;
  logic [1:0]              gnt;
  logic                    sel_b;
  logic                    cur_valid;
  logic [DW-1:0]           cur_data;
  logic                    cur_sop;
  logic                    cur_eop;
  logic                    at_limit;

  // Only a word that starts a packet can request the egress port.
  assign req = {srcB_valid & srcB_sop, srcA_valid & srcA_sop};

  eth_sw_rr_arb2 u_rr_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Word stream of whichever source currently owns the egress.
  assign sel_b     = (state_q == XFER_B) || (state_q == DRAIN_B);
  assign cur_valid = sel_b ? srcB_valid : srcA_valid;
  assign cur_data  = sel_b ? srcB_data  : srcA_data;
  assign cur_sop   = sel_b ? srcB_sop   : srcA_sop;
  assign cur_eop   = sel_b ? srcB_eop   : srcA_eop;
  assign at_limit  = (word_cnt_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    out_valid_d  = 1'b0;
    out_data_d   = '0;
    out_sop_d    = 1'b0;
    out_eop_d    = 1'b0;
    err_len_d    = 1'b0;
    pkt_cnt_a_d  = pkt_cnt_a_q;
    pkt_cnt_b_d  = pkt_cnt_b_q;
    srcA_ready   = 1'b0;
    srcB_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        // A stalled egress must not be handed to anyone.
        if (!port_stall) begin
          if (gnt[0]) begin
            state_d      = XFER_A;
            last_grant_d = SRC_A;
            word_cnt_d   = '0;
          end else if (gnt[1]) begin
            state_d      = XFER_B;
            last_grant_d = SRC_B;
            word_cnt_d   = '0;
          end
        end
      end

      XFER_A, XFER_B: begin
        if (sel_b) srcB_ready = !port_stall;
        else       srcA_ready = !port_stall;

        if (cur_valid && !port_stall) begin
          out_valid_d = 1'b1;
          out_data_d  = cur_data;
          // A stray sop inside a packet is plain data on the egress.
          out_sop_d   = cur_sop && (word_cnt_q == '0);
          // Hitting the length limit without eop closes the packet early.
          out_eop_d   = cur_eop || at_limit;
          err_len_d   = !cur_eop && at_limit;
          word_cnt_d  = word_cnt_q + WORD_CNT_W'(1);

          if (cur_eop || at_limit) begin
            if (sel_b) pkt_cnt_b_d = pkt_cnt_b_q + CNT_W'(1);
            else       pkt_cnt_a_d = pkt_cnt_a_q + CNT_W'(1);

            if (cur_eop)    state_d = IDLE;
            else if (sel_b) state_d = DRAIN_B;
            else            state_d = DRAIN_A;
          end
        end
      end

      DRAIN_A, DRAIN_B: begin
        // Discard the tail of a truncated packet; the egress is not used,
        // so the stall does not apply.
        if (sel_b) srcB_ready = 1'b1;
        else       srcA_ready = 1'b1;

        if (cur_valid && cur_eop) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to B so that A wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_B;
      word_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      err_len_q    <= 1'b0;
      pkt_cnt_a_q  <= '0;
      pkt_cnt_b_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      err_len_q    <= err_len_d;
      pkt_cnt_a_q  <= pkt_cnt_a_d;
      pkt_cnt_b_q  <= pkt_cnt_b_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign err_len   = err_len_q;
  assign pkt_cnt_a = pkt_cnt_a_q;
  assign pkt_cnt_b = pkt_cnt_b_q;
  assign grant_a   = (state_q == XFER_A) || (state_q == DRAIN_A);
  assign grant_b   = (state_q == XFER_B) || (state_q == DRAIN_B);

endmodule

// File: tb/tb_eth_sw_out_arb.sv
// ---------------------------------------------------------------------------
// tb_eth_sw_out_arb
// Self-checking bench for eth_sw_out_arb with a small length limit (4 words)
// and 2-bit packet counters so truncation and counter wrap are reachable.
// Sources are packet queues; a transaction-level model of the scheduling
// rules predicts ready/grant every cycle and the egress word one cycle later.
// ---------------------------------------------------------------------------
module tb_eth_sw_out_arb;

  localparam int DW    = 32;
  localparam int MAX_W = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             srcA_valid, srcA_sop, srcA_eop, srcA_ready;
  logic [DW-1:0]    srcA_data;
  logic             srcB_valid, srcB_sop, srcB_eop, srcB_ready;
  logic [DW-1:0]    srcB_data;
  logic             port_stall;
  logic             out_valid, out_sop, out_eop;
  logic [DW-1:0]    out_data;
  logic             grant_a, grant_b;
  logic [CNT_W-1:0] pkt_cnt_a, pkt_cnt_b;
  logic             err_len;

  always #5 clk = ~clk;

  eth_sw_out_arb #(
    .DW            (DW),
    .MAX_PKT_WORDS (MAX_W),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .srcA_valid (srcA_valid),
    .srcA_data  (srcA_data),
    .srcA_sop   (srcA_sop),
    .srcA_eop   (srcA_eop),
    .srcA_ready (srcA_ready),
    .srcB_valid (srcB_valid),
    .srcB_data  (srcB_data),
    .srcB_sop   (srcB_sop),
    .srcB_eop   (srcB_eop),
    .srcB_ready (srcB_ready),
    .port_stall (port_stall),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .pkt_cnt_a  (pkt_cnt_a),
    .pkt_cnt_b  (pkt_cnt_b),
    .err_len    (err_len)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } word_t;

  word_t         src_a_q[$];
  word_t         src_b_q[$];

  int            vec_count   = 0;
  int            miscompares = 0;

  // Reference model: who owns the egress (-1 none, 0 A, 1 B), whether the
  // owner's packet was cut short, and its position inside the packet.
  int            m_owner;
  bit            m_drain;
  int            m_pos;
  int            m_last;
  int            m_cnt[2];
  bit            e_valid, e_sop, e_eop, e_err;
  logic [DW-1:0] e_data;

  bit            stall_force;
  int            stall_pct;
  int            valid_pct;

  logic [DW-1:0] obs_data[$];
  bit            obs_sop[$];
  bit            obs_eop[$];
  int            obs_cnt_a[$];
  int            grant_log[$];
  int            err_seen;
  bit            prev_ga, prev_gb;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic clearLogs();
    obs_data.delete();
    obs_sop.delete();
    obs_eop.delete();
    obs_cnt_a.delete();
    grant_log.delete();
    err_seen = 0;
  endtask

  // Egress registers seen now reflect what the model predicted last cycle.
  task automatic compareOutputs();
    checkOutput("out_valid", out_valid, e_valid);
    if (e_valid) begin
      checkOutput("out_data", out_data, e_data);
      checkOutput("out_sop", out_sop, e_sop);
      checkOutput("out_eop", out_eop, e_eop);
    end
    checkOutput("err_len", err_len, e_err);
    checkOutput("pkt_cnt_a", pkt_cnt_a, m_cnt[0]);
    checkOutput("pkt_cnt_b", pkt_cnt_b, m_cnt[1]);
    if (out_valid) begin
      obs_data.push_back(out_data);
      obs_sop.push_back(out_sop);
      obs_eop.push_back(out_eop);
    end
    if (out_valid && out_eop) obs_cnt_a.push_back(int'(pkt_cnt_a));
    if (err_len) err_seen++;
    if (grant_a && !prev_ga) grant_log.push_back(0);
    if (grant_b && !prev_gb) grant_log.push_back(1);
    prev_ga = grant_a;
    prev_gb = grant_b;
  endtask

  // One clock cycle: check last cycle's result, drive new inputs, check the
  // handshake, then advance the model by the scheduling rules.
  task automatic applyStimulus();
    word_t ha, hb, w;
    bit    va, vb, stall, er_a, er_b, acc_a, acc_b, acc, ca, cb, cut;
    @(negedge clk);
    compareOutputs();
    stall = stall_force || ($urandom_range(99) < stall_pct);
    ha = '0;
    hb = '0;
    if (src_a_q.size() > 0) ha = src_a_q[0];
    if (src_b_q.size() > 0) hb = src_b_q[0];
    va = (src_a_q.size() > 0) && ($urandom_range(99) < valid_pct);
    vb = (src_b_q.size() > 0) && ($urandom_range(99) < valid_pct);
    port_stall = stall;
    srcA_valid = va;  srcA_data = ha.data;  srcA_sop = ha.sop;  srcA_eop = ha.eop;
    srcB_valid = vb;  srcB_data = hb.data;  srcB_sop = hb.sop;  srcB_eop = hb.eop;
    #1;
    er_a = (m_owner == 0) && (m_drain || !stall);
    er_b = (m_owner == 1) && (m_drain || !stall);
    checkOutput("srcA_ready", srcA_ready, er_a);
    checkOutput("srcB_ready", srcB_ready, er_b);
    checkOutput("grant_a", grant_a, m_owner == 0);
    checkOutput("grant_b", grant_b, m_owner == 1);
    acc_a = va && er_a;
    acc_b = vb && er_b;
    if (acc_a) void'(src_a_q.pop_front());
    if (acc_b) void'(src_b_q.pop_front());

    e_valid = 1'b0;  e_sop = 1'b0;  e_eop = 1'b0;  e_err = 1'b0;  e_data = '0;
    if (m_owner < 0) begin
      if (!stall) begin
        ca = va && ha.sop;
        cb = vb && hb.sop;
        if (ca && cb)  m_owner = (m_last == 1) ? 0 : 1;
        else if (ca)   m_owner = 0;
        else if (cb)   m_owner = 1;
        if (m_owner >= 0) begin
          m_last  = m_owner;
          m_drain = 1'b0;
          m_pos   = 1;
        end
      end
    end else begin
      acc = (m_owner == 0) ? acc_a : acc_b;
      w   = (m_owner == 0) ? ha : hb;
      if (acc && !m_drain) begin
        cut     = !w.eop && (m_pos == MAX_W);
        e_valid = 1'b1;
        e_data  = w.data;
        e_sop   = w.sop && (m_pos == 1);
        e_eop   = w.eop || cut;
        e_err   = cut;
        m_pos++;
        if (e_eop) m_cnt[m_owner] = (m_cnt[m_owner] + 1) % (1 << CNT_W);
        if (w.eop)    m_owner = -1;
        else if (cut) m_drain = 1'b1;
      end else if (acc && m_drain && w.eop) begin
        m_owner = -1;
      end
    end
  endtask

  // Reset is raised while the current inputs are still driven, so it can
  // land in the middle of a packet.
  task automatic resetDut();
    @(negedge clk);
    rst        = 1'b1;
    port_stall = 1'b0;
    @(negedge clk);
    srcA_valid = 1'b0;  srcA_data = '0;  srcA_sop = 1'b0;  srcA_eop = 1'b0;
    srcB_valid = 1'b0;  srcB_data = '0;  srcB_sop = 1'b0;  srcB_eop = 1'b0;
    #1;
    checkOutput("rst_flags", {out_valid, out_sop, out_eop, err_len,
                              grant_a, grant_b, srcA_ready, srcB_ready}, 8'h00);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_pkt_cnt_a", pkt_cnt_a, 0);
    checkOutput("rst_pkt_cnt_b", pkt_cnt_b, 0);
    rst = 1'b0;
    src_a_q.delete();
    src_b_q.delete();
    m_owner = -1;  m_drain = 1'b0;  m_pos = 0;  m_last = 1;
    m_cnt[0] = 0;  m_cnt[1] = 0;
    e_valid = 1'b0;  e_sop = 1'b0;  e_eop = 1'b0;  e_err = 1'b0;  e_data = '0;
    prev_ga = 1'b0;  prev_gb = 1'b0;
    stall_force = 1'b0;
    clearLogs();
  endtask

  task automatic pushPacket(input int src, input int len, input logic [DW-1:0] base,
                            input bit stray_sop);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.data = base + DW'(i);
      w.sop  = (i == 0);
      if (i > 0 && stray_sop && $urandom_range(3) == 0) w.sop = 1'b1;
      w.eop  = (i == len - 1);
      if (src == 0) src_a_q.push_back(w);
      else          src_b_q.push_back(w);
    end
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    while ((src_a_q.size() > 0 || src_b_q.size() > 0 || m_owner >= 0 || e_valid)
           && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("idle_in_budget", n < budget, 1);
  endtask

  task automatic runUntilPos(input int pos, input int budget);
    int n = 0;
    while (!(m_owner >= 0 && m_pos >= pos) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("pos_in_budget", n < budget, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;  port_stall = 1'b0;
    srcA_valid = 1'b0;  srcA_data = '0;  srcA_sop = 1'b0;  srcA_eop = 1'b0;
    srcB_valid = 1'b0;  srcB_data = '0;  srcB_sop = 1'b0;  srcB_eop = 1'b0;
    stall_force = 1'b0;  stall_pct = 0;  valid_pct = 100;
    resetDut();

    $display("[TB] single packet, exactly the length limit");
    pushPacket(0, 4, 32'h1, 1'b0);
    runUntilIdle(50);
    checkOutput("single_words", obs_data.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < obs_data.size()) checkOutput("single_data", obs_data[i], 32'(i + 1));
    if (obs_data.size() == 4) begin
      checkOutput("single_sop", obs_sop[0], 1);
      checkOutput("single_eop", obs_eop[3], 1);
    end
    checkOutput("single_no_err", err_seen, 0);
    checkOutput("single_cnt_a", pkt_cnt_a, 1);

    $display("[TB] tie alternation");
    resetDut();
    pushPacket(0, 2, 32'hA00, 1'b0);
    pushPacket(0, 2, 32'hA10, 1'b0);
    pushPacket(1, 2, 32'hB00, 1'b0);
    pushPacket(1, 2, 32'hB10, 1'b0);
    runUntilIdle(100);
    checkOutput("tie_grants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) checkOutput("tie_order", grant_log[i], i % 2);

    $display("[TB] stall in idle and mid-packet");
    resetDut();
    stall_force = 1'b1;
    pushPacket(0, 5, 32'hA0, 1'b0);
    pushPacket(1, 2, 32'hB0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("stall_no_grant", grant_log.size(), 0);
    stall_force = 1'b0;
    runUntilPos(3, 50);
    stall_force = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus();
    stall_force = 1'b0;
    runUntilIdle(100);
    checkOutput("stall_words", obs_data.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < obs_data.size())
        checkOutput("stall_data", obs_data[i], (i < 4) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i - 4));
    pushPacket(0, 1, 32'h77, 1'b0);
    src_a_q[0].sop = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("nosop_no_grant", grant_a, 0);
    src_a_q.delete();

    $display("[TB] truncation at the length limit");
    resetDut();
    pushPacket(1, 6, 32'hB0, 1'b0);
    runUntilIdle(60);
    checkOutput("trunc_words", obs_data.size(), 4);
    if (obs_data.size() == 4) checkOutput("trunc_eop", obs_eop[3], 1);
    checkOutput("trunc_err", err_seen, 1);
    checkOutput("trunc_cnt_b", pkt_cnt_b, 1);

    $display("[TB] reset mid-packet");
    resetDut();
    pushPacket(0, 6, 32'hC0, 1'b0);
    runUntilPos(2, 50);
    resetDut();
    pushPacket(0, 2, 32'hD0, 1'b0);
    pushPacket(1, 2, 32'hE0, 1'b0);
    runUntilIdle(60);
    checkOutput("after_rst_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) checkOutput("after_rst_first", grant_log[0], 0);

    $display("[TB] packet counter wrap");
    resetDut();
    for (int p = 0; p < 5; p++) pushPacket(0, $urandom_range(1, 3), 32'(p * 16), 1'b0);
    runUntilIdle(100);
    checkOutput("wrap_pkts", obs_cnt_a.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < obs_cnt_a.size()) checkOutput("wrap_cnt", obs_cnt_a[i], (i + 1) % 4);

    $display("[TB] randomized traffic");
    resetDut();
    valid_pct = 70;
    stall_pct = 25;
    for (int b = 0; b < 15; b++) begin
      for (int s = 0; s < 2; s++)
        for (int k = $urandom_range(0, 3); k > 0; k--)
          pushPacket(s, $urandom_range(1, 7), $urandom, 1'b1);
      runUntilIdle(2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
